// File: rtl/cdc_pulse_rx_multi_if.sv
// Event-crossing bundle between a consumer and the receive side of a toggle pulse crossing.
// The slave modport is the crossing itself; the master modport is its consumer/source.
interface cdc_pulse_rx_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] tgl_in;
  logic [CHANNELS-1:0] evt_pulse;
  logic [CHANNELS-1:0] evt_valid;
  logic [CHANNELS-1:0] evt_ready;
  logic [CHANNELS-1:0] overflow;
  logic [CHANNELS-1:0] ovf_clr;

  modport master (
    output tgl_in,
    output evt_ready,
    output ovf_clr,
    input  evt_pulse,
    input  evt_valid,
    input  overflow
  );

  modport slave (
    input  tgl_in,
    input  evt_ready,
    input  ovf_clr,
    output evt_pulse,
    output evt_valid,
    output overflow
  );
endinterface

// File: rtl/cdc_pulse_rx_multi.sv
// Multi-channel toggle-to-pulse receiver: synchronises foreign-domain toggles, emits one-cycle
// pulses and queues events in saturating pending counters drained by valid/ready.
module cdc_pulse_rx_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cdc_pulse_rx_multi_if.slave   bus
);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam int                INIT_W    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic                run;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] edge_ref;
  logic [CHANNELS-1:0] evt_raw;
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] ovf_set;

  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] valid_q;
  logic [CHANNELS-1:0] ovf_q;
  logic [CNT_W-1:0]    cnt     [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];

  // INIT lasts long enough for a level held through reset to reach edge_ref without an event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state <= ST_RUN;
          end else begin
            init_cnt <= init_cnt + INIT_ONE;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  assign run = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      edge_ref <= '0;
    end else begin
      sync_q[0] <= bus.tgl_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      edge_ref <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_raw = sync_q[SYNC_STAGES-1] ^ edge_ref;

  // A full counter with a simultaneous pop absorbs the event; only an unpopped one overflows
  always_comb begin
    evt     = evt_raw & {CHANNELS{run}};
    pop     = valid_q & bus.evt_ready & {CHANNELS{run}};
    ovf_set = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_nxt[c] = cnt[c];
      if (evt[c] && !pop[c]) begin
        if (cnt[c] == CNT_MAX) begin
          ovf_set[c] = 1'b1;
        end else begin
          cnt_nxt[c] = cnt[c] + CNT_ONE;
        end
      end else if (!evt[c] && pop[c]) begin
        cnt_nxt[c] = cnt[c] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
      pulse_q <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
    end else begin
      pulse_q <= evt;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c]     <= cnt_nxt[c];
        valid_q[c] <= (cnt_nxt[c] != '0);
      end
      ovf_q <= ovf_set | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.evt_pulse = pulse_q;
  assign bus.evt_valid = valid_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cdc_pulse_rx_multi.sv
// Self-checking bench for cdc_pulse_rx_multi: directed scenarios plus randomized traffic
// compared against an event-level model of pending counts and overflow flags.
module tb_cdc_pulse_rx_multi;
  localparam int CH      = 4;
  localparam int SS      = 2;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int LAT     = SS + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  cdc_pulse_rx_multi_if #(.CHANNELS(CH)) bus ();

  cdc_pulse_rx_multi #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_cnt [CH];
  bit m_ovf [CH];
  int pulse_seen [CH];
  int sched [$];
  int last_tgl [CH];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] ready, input logic [CH-1:0] clr);
    bus.evt_ready = ready;
    bus.ovf_clr   = clr;
  endtask

  // A toggle driven now is captured on the next edge and its pulse rises LAT edges from now
  task automatic toggle(input int c);
    bus.tgl_in[c] = ~bus.tgl_in[c];
    sched.push_back((cyc + LAT) * 16 + c);
  endtask

  task automatic modelReset();
    sched.delete();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      m_ovf[c] = 1'b0;
    end
  endtask

  task automatic runCycles(input int n);
    logic [CH-1:0] ev;
    logic [CH-1:0] vexp;
    logic [CH-1:0] oexp;
    bit pop;
    bit full;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      ev = '0;
      if (reset_n) begin
        for (int i = sched.size() - 1; i >= 0; i--) begin
          if (sched[i] / 16 == cyc) begin
            ev[sched[i] % 16] = 1'b1;
            sched.delete(i);
          end
        end
        for (int c = 0; c < CH; c++) begin
          pop  = (m_cnt[c] != 0) && bus.evt_ready[c];
          full = (m_cnt[c] == CNT_MAX);
          if (ev[c] && !pop) begin
            if (full) m_ovf[c] = 1'b1;
            else      m_cnt[c]++;
          end else if (!ev[c] && pop) begin
            m_cnt[c]--;
          end
          if (!(ev[c] && !pop && full) && bus.ovf_clr[c]) m_ovf[c] = 1'b0;
        end
      end
      #1;
      for (int c = 0; c < CH; c++) begin
        vexp[c] = (m_cnt[c] != 0);
        oexp[c] = m_ovf[c];
        if (bus.evt_pulse[c] === 1'b1) pulse_seen[c]++;
      end
      checkOutput("pulse", 32'(bus.evt_pulse), 32'(ev));
      checkOutput("valid", 32'(bus.evt_valid), 32'(vexp));
      checkOutput("overflow", 32'(bus.overflow), 32'(oexp));
    end
  endtask

  task automatic drainCheck(input string tag, input int c, input int exp);
    int n;
    n = 0;
    bus.evt_ready[c] = 1'b1;
    while (bus.evt_valid[c] === 1'b1 && n < 20) begin
      runCycles(1);
      n++;
    end
    bus.evt_ready[c] = 1'b0;
    checkOutput(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int base;
    bus.tgl_in = 4'b1010;
    applyStimulus('0, '0);
    modelReset();
    for (int c = 0; c < CH; c++) pulse_seen[c] = 0;

    // Levels held through reset must not turn into events
    runCycles(3);
    reset_n = 1'b1;
    base = pulse_seen[1] + pulse_seen[3];
    runCycles(20);
    checkOutput("t1_no_pulse", 32'(pulse_seen[1] + pulse_seen[3] - base), 32'd0);
    checkOutput("t1_valid", 32'(bus.evt_valid), 32'd0);

    // Single toggle latency and pop
    toggle(0);
    runCycles(2);
    checkOutput("t2_early", 32'(bus.evt_pulse[0]), 32'd0);
    runCycles(1);
    checkOutput("t2_pulse", 32'(bus.evt_pulse[0]), 32'd1);
    runCycles(1);
    checkOutput("t2_one_cycle", 32'(bus.evt_pulse[0]), 32'd0);
    checkOutput("t2_valid", 32'(bus.evt_valid[0]), 32'd1);
    applyStimulus(4'b0001, '0);
    runCycles(1);
    applyStimulus('0, '0);
    checkOutput("t2_drained", 32'(bus.evt_valid[0]), 32'd0);

    // Saturation and overflow on channel 1
    base = pulse_seen[1];
    for (int i = 0; i < 9; i++) begin
      toggle(1);
      runCycles(4);
      if (i == 6) checkOutput("t3_no_ovf_7", 32'(bus.overflow[1]), 32'd0);
      if (i == 7) checkOutput("t3_ovf_8", 32'(bus.overflow[1]), 32'd1);
    end
    checkOutput("t3_pulses", 32'(pulse_seen[1] - base), 32'd9);
    applyStimulus('0, 4'b0010);
    runCycles(1);
    applyStimulus('0, '0);
    checkOutput("t3_ovf_clr", 32'(bus.overflow[1]), 32'd0);

    // Full counter with pop on the landing cycle: no overflow, count unchanged
    toggle(1);
    runCycles(2);
    applyStimulus(4'b0010, '0);
    runCycles(1);
    applyStimulus('0, '0);
    checkOutput("t4_pulse", 32'(bus.evt_pulse[1]), 32'd1);
    checkOutput("t4_no_ovf", 32'(bus.overflow[1]), 32'd0);
    runCycles(2);
    drainCheck("t4_count", 1, 7);

    // Simultaneous events on all channels, pop only on ch2
    toggle(0);
    toggle(2);
    runCycles(4);
    for (int c = 0; c < CH; c++) toggle(c);
    runCycles(2);
    applyStimulus(4'b0100, '0);
    runCycles(1);
    applyStimulus('0, '0);
    checkOutput("t5_pulses", 32'(bus.evt_pulse), 32'hF);
    runCycles(1);
    drainCheck("t5_cnt0", 0, 2);
    drainCheck("t5_cnt1", 1, 1);
    drainCheck("t5_cnt2", 2, 1);
    drainCheck("t5_cnt3", 3, 1);

    // Asynchronous reset with pending events and overflow
    for (int i = 0; i < 8; i++) begin
      toggle(1);
      if (i < 3) toggle(0);
      runCycles(4);
    end
    checkOutput("t6_pre_ovf", 32'(bus.overflow[1]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_rst_pulse", 32'(bus.evt_pulse), 32'd0);
    checkOutput("t6_rst_valid", 32'(bus.evt_valid), 32'd0);
    checkOutput("t6_rst_ovf", 32'(bus.overflow), 32'd0);
    runCycles(2);
    reset_n = 1'b1;
    runCycles(LAT);
    for (int c = 0; c < CH; c++) toggle(c);
    runCycles(4);
    checkOutput("t6_valid_after", 32'(bus.evt_valid), 32'hF);
    for (int c = 0; c < CH; c++) drainCheck("t6_cnt", c, 1);

    // Randomized traffic against the model
    for (int c = 0; c < CH; c++) last_tgl[c] = cyc;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (cyc - last_tgl[c] >= LAT && $urandom_range(0, 2) == 0) begin
          toggle(c);
          last_tgl[c] = cyc;
        end
      end
      applyStimulus(CH'($urandom), ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0);
      runCycles(1);
    end
    applyStimulus('0, '0);
    runCycles(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
